// File: rtl/loc_sram_drain_pkg.sv
// Shared types and defaults for the local vertex SRAM drain engine.
// Element 0 sits in the most significant slice of a row.
package loc_sram_drain_pkg;

    localparam int DEF_ADDR_SPACE = 4;
    localparam int DEF_BW         = 5;
    localparam int DEF_D          = 256;
    localparam int DEF_VID_W      = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_SCAN,
        ST_CLR,
        ST_FIN
    } state_e;

    function automatic int unsigned elem_off(
        input int unsigned idx,
        input int unsigned d,
        input int unsigned bw
    );
        return (d - 1 - idx) * bw;
    endfunction

endpackage

// File: rtl/loc_pending_penc.sv
// Lowest-set-bit priority encoder over the per-row pending mask.
// Index is 0 when nothing is pending; qualify with any.
module loc_pending_penc #(
    parameter int D     = 256,
    parameter int IDX_W = $clog2(D)
) (
    input  logic [D-1:0]     pend,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        for (int i = D - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |pend;

endmodule

// File: rtl/loc_sram_drain.sv
// Drains a run of SRAM rows, streaming non-zero elements as (vid, value).
// Define LOC_SRAM_DRAIN_CLEAR_EN to zero each row after it is drained.
module loc_sram_drain
    import loc_sram_drain_pkg::*;
#(
    parameter int ADDR_SPACE = DEF_ADDR_SPACE,
    parameter int BW         = DEF_BW,
    parameter int D          = DEF_D,
    parameter int VID_W      = DEF_VID_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_SPACE-1:0] start_row,
    input  logic [ADDR_SPACE:0]   num_rows,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_SPACE-1:0] sram_raddr,
    input  logic [D*BW-1:0]       sram_rdata,
    output logic                  sram_wsb,
    output logic [ADDR_SPACE-1:0] sram_waddr,
    output logic [D-1:0]          sram_bytemask,
    output logic [D*BW-1:0]       sram_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VID_W-1:0]      out_vid,
    output logic [BW-1:0]         out_data
);

    localparam int IDX_W = $clog2(D);

`ifdef LOC_SRAM_DRAIN_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [ADDR_SPACE-1:0] row_q, row_d;
    logic [ADDR_SPACE:0]   rem_q, rem_d;
    logic [D*BW-1:0]       buf_q, buf_d;
    logic [D-1:0]          pend_q, pend_d;
    logic [IDX_W-1:0]      idx;
    logic                  any;
    logic                  adv;

    loc_pending_penc #(
        .D     (D),
        .IDX_W (IDX_W)
    ) u_penc (
        .pend (pend_q),
        .idx  (idx),
        .any  (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        pend_d  = pend_q;
        adv     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_rows == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        row_d   = start_row;
                        rem_d   = num_rows;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: state_d = ST_WAIT;
            ST_WAIT: begin
                buf_d = sram_rdata;
                for (int i = 0; i < D; i++) begin
                    pend_d[i] = |sram_rdata[elem_off(i, D, BW) +: BW];
                end
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (any && out_ready) begin
                    pend_d[idx] = 1'b0;
                end
                // Leave on the last handshake so a drained row costs no idle cycle.
                if (pend_d == '0) begin
                    if (CLEAR_EN) begin
                        state_d = ST_CLR;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            ST_CLR: adv = 1'b1;
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (adv) begin
            rem_d   = rem_q - 1'b1;
            row_d   = row_q + 1'b1;
            state_d = (rem_d == '0) ? ST_FIN : ST_RD;
        end
    end

    always_comb begin
        busy       = (state_q != ST_IDLE) && (state_q != ST_FIN);
        done       = (state_q == ST_FIN);
        sram_raddr = row_q;
        out_valid  = (state_q == ST_SCAN) && any;
        out_vid    = '0;
        out_data   = '0;
        if (out_valid) begin
            out_vid  = VID_W'({row_q, idx});
            out_data = buf_q[elem_off(32'(idx), D, BW) +: BW];
        end
`ifdef LOC_SRAM_DRAIN_CLEAR_EN
        sram_wsb      = (state_q != ST_CLR);
        sram_waddr    = (state_q == ST_CLR) ? row_q : '0;
        sram_bytemask = (state_q == ST_CLR) ? '0 : '1;
        sram_wdata    = '0;
`else
        sram_wsb      = 1'b1;
        sram_waddr    = '0;
        sram_bytemask = '1;
        sram_wdata    = '0;
`endif
    end

endmodule

// File: tb/tb_loc_sram_drain.sv
// Randomised scoreboard bench for loc_sram_drain with an SRAM model.
// Expectations come from scanning a reference copy of the row contents.
module tb_loc_sram_drain;

    localparam int AS = 4;
    localparam int BW = 5;
    localparam int D  = 256;
    localparam int VW = 12;
    localparam int NR = 16;
    localparam int RW = D * BW;

`ifdef LOC_SRAM_DRAIN_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct {
        logic [VW-1:0] vid;
        logic [BW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AS-1:0] start_row;
    logic [AS:0]   num_rows;
    logic          busy, done;
    logic [AS-1:0] sram_raddr, sram_waddr;
    logic [RW-1:0] sram_rdata, sram_wdata;
    logic          sram_wsb;
    logic [D-1:0]  sram_bytemask;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] out_vid;
    logic [BW-1:0] out_data;

    logic [RW-1:0] mem [NR];
    logic [RW-1:0] ref_mem [NR];
    logic          sync_req = 1'b0;

    exp_t exp_q[$];
    int   exp_wr_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   ready_mode = 0;
    int   wr_cnt = 0;
    int   bad_mask_cnt = 0;
    bit   first_pend = 0;
    bit   held = 0;
    logic [VW-1:0] held_vid;
    logic [BW-1:0] held_data;

    always #5 clk = ~clk;

    loc_sram_drain dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_row     (start_row),
        .num_rows      (num_rows),
        .busy          (busy),
        .done          (done),
        .sram_raddr    (sram_raddr),
        .sram_rdata    (sram_rdata),
        .sram_wsb      (sram_wsb),
        .sram_waddr    (sram_waddr),
        .sram_bytemask (sram_bytemask),
        .sram_wdata    (sram_wdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_vid       (out_vid),
        .out_data      (out_data)
    );

    function automatic void check(input string name, input longint got, input longint exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endfunction

    function automatic logic [RW-1:0] expand(input logic [D-1:0] bm);
        logic [RW-1:0] m;
        m = '0;
        for (int i = 0; i < D; i++) m[(D-1-i)*BW +: BW] = {BW{bm[i]}};
        return m;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read, masked write, bulk load from the reference
    always @(posedge clk) begin
        sram_rdata <= mem[sram_raddr];
        if (sync_req) begin
            for (int r = 0; r < NR; r++) mem[r] <= ref_mem[r];
        end else if (!sram_wsb) begin
            mem[sram_waddr] <= (mem[sram_waddr] & expand(sram_bytemask))
                             | (sram_wdata & ~expand(sram_bytemask));
        end
    end

    // Monitor: picks ready for the coming edge, then checks what will transfer
    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else begin
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_vid", out_vid, held_vid);
                check("hold_data", out_data, held_data);
                held = 0;
            end
            if (out_valid && first_pend) begin
                check("first_latency", cyc - start_cyc, 3);
                first_pend = 0;
            end
            if (out_valid && !out_ready) begin
                held = 1;
                held_vid = out_vid;
                held_data = out_data;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_vid, -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_vid", out_vid, e.vid);
                    check("out_data", out_data, e.data);
                end
            end
            if (!sram_wsb) begin
                wr_cnt++;
                if (exp_wr_q.size() == 0) check("unexpected_wr", sram_waddr, -1);
                else check("wr_addr", sram_waddr, exp_wr_q.pop_front());
                check("wr_mask", sram_bytemask, 0);
                check("wr_data", (sram_wdata == '0), 1);
            end else if (sram_bytemask != '1) begin
                bad_mask_cnt++;
            end
        end
    end

    task automatic load();
        @(negedge clk);
        sync_req = 1'b1;
        @(posedge clk);
        #1 sync_req = 1'b0;
    endtask

    task automatic clear_ref();
        for (int r = 0; r < NR; r++) ref_mem[r] = '0;
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_vid"}, out_vid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_wsb"}, sram_wsb, 1);
        check({tag, "_mask1"}, (sram_bytemask == '1), 1);
        check({tag, "_wdata0"}, (sram_wdata == '0), 1);
        check({tag, "_raddr"}, sram_raddr, 0);
        check({tag, "_waddr"}, sram_waddr, 0);
    endtask

    task automatic run(input int sr, input int nr, input int mode);
        int lat_exp, n, r, budget, bad_rows, wr_exp;
        bit got;
        logic [BW-1:0] e;
        exp_t x;
        ready_mode = mode;
        lat_exp = 1;
        wr_exp = 0;
        for (int k = 0; k < nr; k++) begin
            r = (sr + k) % NR;
            n = 0;
            for (int i = 0; i < D; i++) begin
                e = ref_mem[r][(D-1-i)*BW +: BW];
                if (e != 0) begin
                    x.vid = VW'(r * D + i);
                    x.data = e;
                    exp_q.push_back(x);
                    n++;
                end
            end
            lat_exp += 2 + ((n == 0) ? 1 : n);
            if (CLR) begin
                lat_exp += 1;
                wr_exp++;
                exp_wr_q.push_back(r);
                ref_mem[r] = '0;
            end
        end
        wr_cnt = 0;
        bad_mask_cnt = 0;
        @(negedge clk);
        first_pend = (exp_q.size() > 0);
        start = 1'b1;
        start_row = AS'(sr);
        num_rows = (AS+1)'(nr);
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", busy, (nr > 0) ? 1 : 0);
        budget = 10 * lat_exp + 50;
        got = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        check("done_seen", got, 1);
        if (got) begin
            if (mode == 0) check("done_latency", cyc - start_cyc, lat_exp);
            check("busy_at_done", busy, 0);
        end
        check("leftover_out", exp_q.size(), 0);
        check("leftover_wr", exp_wr_q.size(), 0);
        check("wr_count", wr_cnt, wr_exp);
        check("idle_mask", bad_mask_cnt, 0);
        bad_rows = 0;
        for (int q = 0; q < NR; q++) if (mem[q] != ref_mem[q]) bad_rows++;
        check("mem_rows", bad_rows, 0);
        exp_q.delete();
        exp_wr_q.delete();
        first_pend = 0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < NR; r++) begin
            ref_mem[r] = '0;
            for (int i = 0; i < D; i++) begin
                if ($urandom_range(0, 31) == 0) begin
                    ref_mem[r][(D-1-i)*BW +: BW] = BW'($urandom_range(1, 31));
                end
            end
        end
    endtask

    task automatic row3_data();
        clear_ref();
        ref_mem[3][(D-1-0)*BW +: BW] = 5'd7;
        ref_mem[3][(D-1-100)*BW +: BW] = 5'd1;
        ref_mem[3][(D-1-255)*BW +: BW] = 5'd31;
        load();
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        start = 1'b0;
        start_row = '0;
        num_rows = '0;
        clear_ref();
        for (int r = 0; r < NR; r++) mem[r] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_rst("reset");

        row3_data();
        run(3, 1, 0);
        row3_data();
        run(3, 1, 1);

        clear_ref();
        for (int k = 0; k < 4; k++) begin
            ref_mem[(14 + k) % NR][(D-1-2)*BW +: BW] = BW'((14 + k) % NR + 1);
        end
        load();
        run(14, 4, 0);

        clear_ref();
        load();
        run(0, 16, 0);
        run(7, 0, 0);

        fill_random();
        load();
        run(5, 2, 2);
        run(5, 2, 0);

        for (int t = 0; t < 6; t++) begin
            fill_random();
            load();
            run($urandom_range(0, 15), $urandom_range(0, 16), $urandom_range(0, 2));
        end

        // Reset while stalled in SCAN, after a start issued while busy
        clear_ref();
        ref_mem[9][(D-1-10)*BW +: BW] = 5'd3;
        ref_mem[9][(D-1-20)*BW +: BW] = 5'd4;
        load();
        ready_mode = 3;
        @(negedge clk);
        start = 1'b1;
        start_row = 4'd9;
        num_rows = 5'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_valid", out_valid, 1);
        check("stall_vid", out_vid, 9 * D + 10);
        start = 1'b1;
        start_row = 4'd2;
        num_rows = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("ignored_vid", out_vid, 9 * D + 10);
        check("ignored_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_rst("midrun");
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid || done || busy) cnt++;
        end
        check("post_reset_quiet", cnt, 0);
        cnt = 0;
        for (int q = 0; q < NR; q++) if (mem[q] != ref_mem[q]) cnt++;
        check("post_reset_mem", cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
